// File: rtl/sdram_wr_burst_ctrl.sv
// Write-path burst controller: pops one fixed-length burst from the write FIFO per SDRAM write grant.
// Optional macro SDRAM_WR_ADDR_WRAP_EN: wrap the write address to ADDR_BASE instead of halting at ADDR_MAX.
module sdram_wr_burst_ctrl #(
  parameter int                 DATA_W    = 16,
  parameter int                 CNT_W     = 9,
  parameter int                 ADDR_W    = 24,
  parameter int                 BURST_LEN = 8,
  parameter logic [ADDR_W-1:0]  ADDR_BASE = ADDR_W'(24'h000000),
  parameter logic [ADDR_W-1:0]  ADDR_MAX  = ADDR_W'(24'hFFFFF8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  fifo_count,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data_req,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              busy,
  output logic              err_underrun,
  output logic              addr_end
);

  localparam int                BEAT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    DATA      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [BEAT_W-1:0]   beat_r, beat_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic                addr_end_r, addr_end_nxt_s;
  logic                err_r, err_nxt_s;
  logic                wr_req_r, busy_r;
  logic                fifo_ren_s;

  // Next-state, beat counting, address advance and the combinational FIFO pop.
  always_comb begin
    state_nxt_s    = state_r;
    beat_nxt_s     = beat_r;
    addr_nxt_s     = addr_r;
    addr_end_nxt_s = addr_end_r;
    err_nxt_s      = err_r;
    fifo_ren_s     = 1'b0;
    case (state_r)
      IDLE: begin
        beat_nxt_s = '0;
        if ((fifo_count >= BURST_CNT) && !addr_end_r) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (wr_ack) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = REQ;
        end
      end
      DATA: begin
        fifo_ren_s = wr_data_req & ~fifo_empty;
        if (wr_data_req) begin
          // An empty FIFO still consumes the beat so the burst length on SDRAM stays fixed.
          beat_nxt_s = beat_r + BEAT_W'(1);
          if (fifo_empty) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = err_r;
          end
          if (beat_r == BEAT_LAST) begin
            state_nxt_s = WAIT_DONE;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      WAIT_DONE: begin
        if (wr_done) begin
          state_nxt_s = IDLE;
          if (addr_r == ADDR_MAX) begin
`ifdef SDRAM_WR_ADDR_WRAP_EN
            addr_nxt_s = ADDR_BASE;
`else
            addr_end_nxt_s = 1'b1;
`endif
          end else begin
            addr_nxt_s = addr_r + ADDR_STEP;
          end
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; wr_req/busy are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      beat_r     <= '0;
      addr_r     <= ADDR_BASE;
      addr_end_r <= 1'b0;
      err_r      <= 1'b0;
      wr_req_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      beat_r     <= beat_nxt_s;
      addr_r     <= addr_nxt_s;
      addr_end_r <= addr_end_nxt_s;
      err_r      <= err_nxt_s;
      wr_req_r   <= (state_nxt_s == REQ);
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

  assign fifo_ren     = fifo_ren_s;
  assign wr_req       = wr_req_r;
  assign wr_addr      = addr_r;
  assign wr_data      = fifo_dout;
  assign busy         = busy_r;
  assign err_underrun = err_r;
  assign addr_end     = addr_end_r;

endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Directed bench for sdram_wr_burst_ctrl with a FIFO model and a data scoreboard.
// ADDR_MAX is shrunk to 16 so address-space exhaustion is reachable.
module tb_sdram_wr_burst_ctrl;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 9;
  localparam int ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CNT_W-1:0]  fifo_count = '0;
  logic              fifo_empty = 1'b0;
  logic              fifo_ren;
  logic [DATA_W-1:0] fifo_dout;
  logic              wr_req;
  logic              wr_ack = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data_req = 1'b0;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done = 1'b0;
  logic              busy;
  logic              err_underrun;
  logic              addr_end;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  logic [DATA_W-1:0] fifo_mem [0:255];
  logic [7:0]        rd_ptr;
  logic [7:0]        wr_ptr = 8'd0;
  logic [DATA_W-1:0] seq = 16'hA000;
  logic [DATA_W-1:0] sb_q [$];

  sdram_wr_burst_ctrl #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .BURST_LEN(8),
    .ADDR_BASE(24'h000000), .ADDR_MAX(24'h000010)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo_count(fifo_count), .fifo_empty(fifo_empty),
    .fifo_ren(fifo_ren), .fifo_dout(fifo_dout), .wr_req(wr_req), .wr_ack(wr_ack),
    .wr_addr(wr_addr), .wr_data_req(wr_data_req), .wr_data(wr_data),
    .wr_done(wr_done), .busy(busy), .err_underrun(err_underrun), .addr_end(addr_end)
  );

  always #5 clk = ~clk;

  // FIFO read side: registered data one cycle after a pop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= 8'd0;
      fifo_dout <= '0;
    end else if (fifo_ren) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && fifo_ren) pops <= pops + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data();
    logic [DATA_W-1:0] exp;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_underflow: observed=%0h expected=none", wr_data);
    end else begin
      exp = sb_q.pop_front();
      chk("wr_data", 32'(wr_data), 32'(exp));
    end
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr] = seq;
      sb_q.push_back(seq);
      wr_ptr = wr_ptr + 8'd1;
      seq    = seq + 16'd1;
    end
  endtask

  task automatic do_beats(input bit gap, input int eb);
    bit pend = 1'b0;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if (pend) chk_data();
      wr_data_req = 1'b1;
      fifo_empty  = (b == eb);
      #1;
      chk("fifo_ren_beat", 32'(fifo_ren), 32'(b != eb));
      pend = (b != eb);
      if (gap) begin
        @(negedge clk);
        if (pend) chk_data();
        pend        = 1'b0;
        wr_data_req = 1'b0;
        fifo_empty  = 1'b0;
      end
    end
    @(negedge clk);
    if (pend) chk_data();
    wr_data_req = 1'b0;
    fifo_empty  = 1'b0;
  endtask

  task automatic run_burst(input logic [ADDR_W-1:0] exp_addr, input bit gap, input int eb);
    int p0;
    load_words(8);
    @(negedge clk);
    fifo_count = 9'd8;
    @(negedge clk); #1;
    chk("wr_req_rise", 32'(wr_req), 32'd1);
    chk("wr_addr_req", 32'(wr_addr), 32'(exp_addr));
    chk("busy_req", 32'(busy), 32'd1);
    repeat (2) begin
      @(negedge clk); #1;
      chk("wr_req_hold", 32'(wr_req), 32'd1);
    end
    @(negedge clk);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack     = 1'b0;
    fifo_count = 9'd0;
    #1;
    chk("wr_req_fall", 32'(wr_req), 32'd0);
    p0 = pops;
    do_beats(gap, eb);
    @(negedge clk);
    wr_data_req = 1'b1;
    #1;
    chk("ren_wait_done", 32'(fifo_ren), 32'd0);
    chk("busy_wait_done", 32'(busy), 32'd1);
    chk("wr_addr_stable", 32'(wr_addr), 32'(exp_addr));
    @(negedge clk);
    wr_data_req = 1'b0;
    wr_done     = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    #1;
    chk("busy_fall", 32'(busy), 32'd0);
    chk("pop_count", 32'(pops - p0), (eb < 8) ? 32'd7 : 32'd8);
  endtask

  initial begin
    // Reset values while held in reset.
    #3;
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_fifo_ren", 32'(fifo_ren), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_err", 32'(err_underrun), 32'd0);
    chk("rst_addr_end", 32'(addr_end), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Stray ack/done in IDLE are ignored.
    @(negedge clk); wr_ack = 1'b1; wr_done = 1'b1;
    @(negedge clk); wr_ack = 1'b0; wr_done = 1'b0; #1;
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_addr", 32'(wr_addr), 32'd0);

    // One word short of a burst never requests.
    fifo_count = 9'd7;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      chk("below_thresh", 32'(wr_req), 32'd0);
    end

    run_burst(24'd0, 1'b0, 8);
    chk("addr_after_b1", 32'(wr_addr), 32'd8);
    run_burst(24'd8, 1'b1, 8);
    chk("addr_after_b2", 32'(wr_addr), 32'd16);

    // Burst at 16 aborted by reset during beat 3.
    load_words(8);
    @(negedge clk); fifo_count = 9'd8;
    @(negedge clk); #1;
    chk("abort_req", 32'(wr_req), 32'd1);
    chk("abort_addr", 32'(wr_addr), 32'd16);
    @(negedge clk); wr_ack = 1'b1;
    @(negedge clk); wr_ack = 1'b0; fifo_count = 9'd0;
    @(negedge clk); wr_data_req = 1'b1;
    @(negedge clk); chk_data(); wr_data_req = 1'b1;
    @(negedge clk); chk_data(); wr_data_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_req", 32'(wr_req), 32'd0);
    chk("mid_rst_fifo_ren", 32'(fifo_ren), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    wr_data_req = 1'b0;
    sb_q.delete();
    wr_ptr = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;

    run_burst(24'd0, 1'b0, 8);
    chk("addr_after_clean", 32'(wr_addr), 32'd8);
    chk("err_clean", 32'(err_underrun), 32'd0);
    run_burst(24'd8, 1'b0, 4);
    chk("err_set", 32'(err_underrun), 32'd1);
    chk("addr_after_underrun", 32'(wr_addr), 32'd16);
    run_burst(24'd16, 1'b1, 8);
    chk("err_sticky", 32'(err_underrun), 32'd1);

`ifdef SDRAM_WR_ADDR_WRAP_EN
    chk("wrap_addr", 32'(wr_addr), 32'd0);
    chk("wrap_addr_end", 32'(addr_end), 32'd0);
    run_burst(24'd0, 1'b0, 8);
    chk("addr_after_wrap", 32'(wr_addr), 32'd8);
`else
    chk("halt_addr", 32'(wr_addr), 32'd16);
    chk("halt_addr_end", 32'(addr_end), 32'd1);
    load_words(8);
    @(negedge clk); fifo_count = 9'd8;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("halt_no_req", 32'(wr_req), 32'd0);
    end
    chk("halt_addr_end_held", 32'(addr_end), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
